// File: rtl/recv_img_if.sv
// recv_img_if: bundles the UART line and the BRAM write side of recv_img.
//   rx         UART line into the receiver (idle high)
//   pixel_out  BRAM write data
//   address    BRAM write address
//   we         BRAM write enable, one-cycle pulse per pixel
//   busy       image reception in progress
//   img_ready  one-cycle pulse after the last pixel of an image is written
//   frame_err  one-cycle pulse when a byte is dropped for a bad stop bit
// master: the receiver side; slave: line driver / BRAM + downstream consumer.
interface recv_img_if #(
  parameter int BIT_DEPTH = 8,
  parameter int ADDR_W    = 12
);
  logic                 rx;
  logic [BIT_DEPTH-1:0] pixel_out;
  logic [ADDR_W-1:0]    address;
  logic                 we;
  logic                 busy;
  logic                 img_ready;
  logic                 frame_err;

  modport master (
    input  rx,
    output pixel_out, address, we, busy, img_ready, frame_err
  );

  modport slave (
    output rx,
    input  pixel_out, address, we, busy, img_ready, frame_err
  );
endinterface

// File: rtl/recv_img.sv
// recv_img: UART (8N1) receive front end for the image path. Each received
// byte becomes one pixel written to the image BRAM at sequential addresses;
// img_ready pulses once the last pixel of an image has been written.
// Ports:
//   clk     system clock, all logic on posedge
//   rst_in  asynchronous, active-high reset
//   bus     recv_img_if.master (rx in; pixel_out/address/we/busy/
//           img_ready/frame_err out)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on the synchronised rx
// START     | half a bit-time in; confirm the start bit or reject a glitch
// DATA      | sampling 8 data bits mid-bit, LSB first
// STOP      | sampling the stop bit; high = byte valid, low = framing error
// WAIT_HIGH | after a framing error, wait for the line to return high
module recv_img #(
  parameter int BRAM_LENGTH     = 64*64,
  parameter int BIT_DEPTH       = 8,   // one UART byte per pixel, must be 8
  parameter int CLOCKS_PER_BAUD = 50
) (
  input  logic       clk,
  input  logic       rst_in,
  recv_img_if.master bus
);
  localparam int ADDR_W = $clog2(BRAM_LENGTH);
  localparam int BAUD_W = $clog2(CLOCKS_PER_BAUD);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLOCKS_PER_BAUD/2 - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(BRAM_LENGTH - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(BIT_DEPTH - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic                 r_rx_m;
  logic                 r_rx_s;
  logic [2:0]           r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [2:0]           r_bit;
  logic [BIT_DEPTH-1:0] r_shift;
  logic [ADDR_W-1:0]    r_idx;
  logic [ADDR_W-1:0]    r_addr;
  logic [BIT_DEPTH-1:0] r_pixel;
  logic                 r_we;
  logic                 r_busy;
  logic                 r_img_ready;
  logic                 r_frame_err;

  // rx is asynchronous to clk; flops reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= bus.rx;
      r_rx_s <= r_rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_idx       <= '0;
      r_addr      <= '0;
      r_pixel     <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_img_ready <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_we        <= 1'b0;
      r_img_ready <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_baud  <= '0;
          end
        end
        S_START: begin
          if (r_baud == BAUD_HALF) begin
            if (!r_rx_s) begin
              r_state <= S_DATA;
              r_baud  <= '0;
              r_bit   <= '0;
              // First confirmed start bit of an image opens the frame.
              if (r_idx == '0) r_busy <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_shift <= {r_rx_s, r_shift[BIT_DEPTH-1:1]};
            if (r_bit == BIT_LAST) r_state <= S_STOP;
            else                   r_bit   <= r_bit + 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_rx_s) begin
              r_we    <= 1'b1;
              r_pixel <= r_shift;
              r_addr  <= r_idx;
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (r_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Index advances the cycle after the write pulse; the last pixel wraps
      // the image and closes the frame. Placed after the FSM so the busy
      // clear wins over any set in the same cycle.
      if (r_we) begin
        if (r_idx == IDX_LAST) begin
          r_idx       <= '0;
          r_addr      <= '0;
          r_img_ready <= 1'b1;
          r_busy      <= 1'b0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign bus.pixel_out = r_pixel;
  assign bus.address   = r_addr;
  assign bus.we        = r_we;
  assign bus.busy      = r_busy;
  assign bus.img_ready = r_img_ready;
  assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_recv_img.sv
module tb_recv_img;
  localparam int CPB = 50;
  localparam int LEN = 16;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk = ~clk;

  recv_img_if #(.BIT_DEPTH(8), .ADDR_W(4)) bus ();

  recv_img #(
    .BRAM_LENGTH(LEN), .BIT_DEPTH(8), .CLOCKS_PER_BAUD(CPB)
  ) dut (
    .clk(clk), .rst_in(rst_in), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] wq_a[$];
  logic [7:0] wq_d[$];
  int we_cyc = 0, fe_cnt = 0, rdy_cnt = 0, rdy_gap = 0, viol = 0;
  logic [3:0] rdy_addr = '1;
  logic rdy_busy = 1'b1;
  logic p_we = 0, p_fe = 0, p_rdy = 0;
  int t_fall = 0;

  always @(negedge clk) begin
    if (!rst_in) begin
      if (bus.we) begin
        wq_a.push_back(bus.address);
        wq_d.push_back(bus.pixel_out);
        we_cyc = cyc;
      end
      if (bus.frame_err) fe_cnt++;
      if (bus.img_ready) begin
        rdy_cnt++;
        rdy_gap  = cyc - we_cyc;
        rdy_addr = bus.address;
        rdy_busy = bus.busy;
      end
      if ((bus.we && p_we) || (bus.frame_err && p_fe) ||
          (bus.img_ready && p_rdy) || (bus.we && bus.frame_err)) viol++;
    end
    p_we  = bus.we;
    p_fe  = bus.frame_err;
    p_rdy = bus.img_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call on a negedge; returns on the negedge ending the stop bit.
  task automatic send_byte(input logic [7:0] d, input logic stop);
    bus.rx = 1'b0;
    t_fall = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  int b;
  int fe0;

  initial begin
    bus.rx = 1'b1;
    rst_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_we", bus.we, 0);
    chk("rst_pixel", bus.pixel_out, 0);
    chk("rst_addr", bus.address, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_img_ready", bus.img_ready, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    rst_in = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5
    send_byte(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    chk("a5_we_count", wq_a.size(), 1);
    chk("a5_addr", wq_a[0], 0);
    chk("a5_data", wq_d[0], 8'hA5);
    chk("a5_latency", we_cyc - t_fall, 2 + (19*CPB)/2 + 1);
    chk("a5_busy", bus.busy, 1);
    chk("a5_pixel_hold", bus.pixel_out, 8'hA5);

    // Start-bit glitch
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    bus.rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_we_count", wq_a.size(), 1);
    chk("glitch_fe_count", fe_cnt, 0);
    chk("glitch_busy", bus.busy, 1);

    // Framing error on 0x3C, then 0x11 lands at the same index
    send_byte(8'h3C, 1'b0);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr_fe_count", fe_cnt, 1);
    chk("ferr_we_count", wq_a.size(), 1);
    chk("ferr_busy", bus.busy, 1);
    send_byte(8'h11, 1'b1);
    repeat (20) @(negedge clk);
    chk("b11_we_count", wq_a.size(), 2);
    chk("b11_addr", wq_a[1], 1);
    chk("b11_data", wq_d[1], 8'h11);
    chk("b11_addr_hold", bus.address, 1);

    // Full image of 16 back-to-back bytes from a fresh index
    rst_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("img_busy_before", bus.busy, 0);
    b = wq_a.size();
    for (int i = 0; i < LEN; i++) begin
      if (i == 1) chk("img_busy_during", bus.busy, 1);
      send_byte(8'(i), 1'b1);
    end
    repeat (20) @(negedge clk);
    chk("img_we_count", wq_a.size() - b, LEN);
    for (int i = 0; i < LEN; i++) begin
      chk($sformatf("img_addr_%0d", i), wq_a[b+i], 32'(i));
      chk($sformatf("img_data_%0d", i), wq_d[b+i], 32'(i));
    end
    chk("img_ready_count", rdy_cnt, 1);
    chk("img_ready_gap", rdy_gap, 1);
    chk("img_ready_addr", rdy_addr, 0);
    chk("img_ready_busy", rdy_busy, 0);
    chk("img_after_addr", bus.address, 0);
    chk("img_after_busy", bus.busy, 0);

    // Reset in the middle of the 3rd byte's data bits
    b = wq_a.size();
    send_byte(8'h81, 1'b1);
    send_byte(8'h42, 1'b1);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
    repeat (3*CPB) @(negedge clk);
    chk("prerst_addr", bus.address, 1);
    chk("prerst_pixel", bus.pixel_out, 8'h42);
    chk("prerst_busy", bus.busy, 1);
    rst_in = 1'b1;
    #1;
    chk("midrst_pixel", bus.pixel_out, 0);
    chk("midrst_addr", bus.address, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_we", bus.we, 0);
    repeat (5) @(negedge clk);
    rst_in = 1'b0;
    repeat (20) @(negedge clk);
    b = wq_a.size();
    send_byte(8'h7E, 1'b1);
    repeat (20) @(negedge clk);
    chk("b7e_we_count", wq_a.size() - b, 1);
    chk("b7e_addr", wq_a[b], 0);
    chk("b7e_data", wq_d[b], 8'h7E);

    // Line held low for 20 bit-times
    fe0 = fe_cnt;
    b = wq_a.size();
    bus.rx = 1'b0;
    repeat (20*CPB) @(negedge clk);
    chk("low_fe_count", fe_cnt - fe0, 1);
    chk("low_we_count", wq_a.size() - b, 0);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'hC3, 1'b1);
    repeat (20) @(negedge clk);
    chk("bc3_we_count", wq_a.size() - b, 1);
    chk("bc3_addr", wq_a[b], 1);
    chk("bc3_data", wq_d[b], 8'hC3);
    chk("low_fe_final", fe_cnt - fe0, 1);

    chk("pulse_rules", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
